// File: rtl/i2c_master_burst_if.sv
// Command, write-data and read-data handshake bundle of the burst I2C master.
// The master modport is the control side; the slave modport is the I2C controller.
interface i2c_master_burst_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rw;
    logic [6:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       wr_data;
    logic             wr_req;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             done;
    logic             nack;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data,
        input  cmd_ready, wr_req, rd_data, rd_valid, done, nack
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data,
        output cmd_ready, wr_req, rd_data, rd_valid, done, nack
    );
endinterface

// File: rtl/i2c_master_burst.sv
// Single-master I2C controller running START, address, 0..2^LEN_W-1 data bytes, STOP.
// Pin levels are decoded from the FSM and registered, so SCL/SDA trail the state by one clk.
module i2c_master_burst #(
    parameter int CLK_DIV = 125,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_burst_if.slave  host,
    output logic               SCL,
    inout  wire                SDA
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    localparam int QW = $clog2(CLK_DIV);

    state_t           state;
    logic [QW-1:0]    qcnt;
    logic [1:0]       phase;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic [LEN_W-1:0] remaining;
    logic             rw;
    logic             ack_low;
    logic             sampled;
    logic             scl_q;
    logic             sda_low;
    logic             scl_nxt;
    logic             sda_nxt;
    logic             q_end;
    logic             slot_end;
    logic             sample_now;
    logic             first_wr;
    logic             sda_in;

    assign sda_in         = SDA;
    assign SDA            = sda_low ? 1'b0 : 1'bz;
    assign SCL            = scl_q;
    assign host.cmd_ready = (state == IDLE);

    assign q_end      = (qcnt == QW'(CLK_DIV - 1));
    assign slot_end   = q_end && (phase == 2'd3);
    // First clk of state-Q3 is the last clk of Q2 as seen on the pins.
    assign sample_now = (phase == 2'd3) && (qcnt == '0);
    assign first_wr   = (state == WR_BYTE) && (bitcnt == 3'd0) && (phase == 2'd0) && (qcnt == '0);

    // Pin levels for the current state/phase; registered below to keep the pins glitch-free.
    always_comb begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b0;
        unique case (state)
            IDLE: ;
            START: sda_nxt = phase[1];
            ADDR: begin
                scl_nxt = phase[1];
                sda_nxt = ~shreg[7];
            end
            WR_BYTE: begin
                scl_nxt = phase[1];
                sda_nxt = first_wr ? ~host.wr_data[7] : ~shreg[7];
            end
            ADDR_ACK, WR_ACK, RD_BYTE: scl_nxt = phase[1];
            RD_ACK: begin
                scl_nxt = phase[1];
                sda_nxt = ack_low;
            end
            STOP: begin
                scl_nxt = (phase != 2'd0);
                sda_nxt = ~phase[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            qcnt          <= '0;
            phase         <= '0;
            bitcnt        <= '0;
            shreg         <= '0;
            remaining     <= '0;
            rw            <= 1'b0;
            ack_low       <= 1'b0;
            sampled       <= 1'b1;
            scl_q         <= 1'b1;
            sda_low       <= 1'b0;
            host.wr_req   <= 1'b0;
            host.rd_valid <= 1'b0;
            host.rd_data  <= '0;
            host.done     <= 1'b0;
            host.nack     <= 1'b0;
        end else begin
            scl_q         <= scl_nxt;
            sda_low       <= sda_nxt;
            host.wr_req   <= 1'b0;
            host.rd_valid <= 1'b0;
            host.done     <= 1'b0;
            if (state == IDLE) begin
                qcnt  <= '0;
                phase <= '0;
                if (host.cmd_valid) begin
                    state     <= START;
                    rw        <= host.cmd_rw;
                    shreg     <= {host.cmd_addr, host.cmd_rw};
                    remaining <= host.cmd_len;
                    bitcnt    <= '0;
                    host.nack <= 1'b0;
                end
            end else begin
                qcnt <= q_end ? '0 : qcnt + QW'(1);
                if (q_end) phase <= phase + 2'd1;
                if (sample_now) begin
                    sampled <= sda_in;
                    if (state == RD_BYTE) begin
                        shreg <= {shreg[6:0], sda_in};
                        if (bitcnt == 3'd7) begin
                            host.rd_data  <= {shreg[6:0], sda_in};
                            host.rd_valid <= 1'b1;
                        end
                    end
                end
                if (first_wr) shreg <= host.wr_data;
                // Slot boundary: the ACK bit decides between the next byte, STOP, or abort on NACK.
                if (slot_end) begin
                    unique case (state)
                        START: state <= ADDR;
                        ADDR, WR_BYTE: begin
                            bitcnt <= bitcnt + 3'd1;
                            shreg  <= {shreg[6:0], 1'b0};
                            if (bitcnt == 3'd7) begin
                                state <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                                if (state == WR_BYTE) remaining <= remaining - LEN_W'(1);
                            end
                        end
                        ADDR_ACK, WR_ACK: begin
                            if (sampled) begin
                                host.nack <= 1'b1;
                                state     <= STOP;
                            end else if (remaining == '0) begin
                                state <= STOP;
                            end else if (rw) begin
                                state <= RD_BYTE;
                            end else begin
                                state       <= WR_BYTE;
                                host.wr_req <= 1'b1;
                            end
                        end
                        RD_BYTE: begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                state     <= RD_ACK;
                                ack_low   <= (remaining != LEN_W'(1));
                                remaining <= remaining - LEN_W'(1);
                            end
                        end
                        RD_ACK: state <= (remaining == '0) ? STOP : RD_BYTE;
                        STOP: begin
                            state     <= IDLE;
                            host.done <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/i2c_master_burst.md
Name: i2c_master_burst

Overview:
Parametrised single-master I2C controller, the successor to the fixed single-byte I2C master. Runs complete transactions: START, 7-bit address + R/W, 0..2^LEN_W-1 data bytes (write or read), STOP. It adds a programmable SCL rate, multi-byte bursts, ACK checking with a NACK flag, and per-byte data handshakes. Sits between the system-side control FSM and the board SDA/SCL pins.

Parameters:
CLK_DIV, 125, clk cycles per quarter SCL bit period (legal range >= 2).
LEN_W, 4, width of the byte-count field.

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
cmd_valid  in  1  request a transaction.
cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid && cmd_ready.
cmd_rw  in  1  0 = write, 1 = read.
cmd_addr  in  7  slave address.
cmd_len  in  LEN_W  byte count; 0 = address-only probe.
wr_data  in  8  next write byte; sampled in the cycle wr_req is high.
wr_req  out  1  one-cycle pulse per write byte.
rd_data  out  8  received byte; held until the next rd_valid.
rd_valid  out  1  one-cycle pulse per received byte.
done  out  1  one-cycle pulse after STOP completes.
nack  out  1  sticky error flag; cleared on the next command accept.
SCL  out  1  push-pull SCL (single master, no clock stretching).
SDA  inout  1  open-drain: drives 0 or high-Z, never 1.

Behaviour:
- Reset (async, while rst=0): state IDLE, SCL=1, SDA=Z, cmd_ready=1, wr_req=rd_valid=done=nack=0, rd_data=0. Reset mid-transaction aborts immediately; no STOP is generated.
- Timing base:
  - Quarter counter 0..CLK_DIV-1; phases Q0..Q3 per bit; every bit slot lasts 4*CLK_DIV cycles.
  - Data bit: SCL=0 in Q0/Q1 and 1 in Q2/Q3. SDA is updated at the start of Q0 and is stable while SCL is high.
  - SDA is sampled in the last clk cycle of Q2.
- On accept: latch cmd_rw, cmd_addr, cmd_len; clear nack; cmd_ready drops the next cycle.
- FSM states: IDLE -> START -> ADDR(8 bits) -> ADDR_ACK -> {WR_BYTE -> WR_ACK}* or {RD_BYTE -> RD_ACK}* -> STOP -> IDLE.
- START slot: SCL=1 throughout; SDA released in Q0/Q1, driven 0 in Q2/Q3.
- ADDR: shifts {cmd_addr, cmd_rw} MSB first.
- ADDR_ACK / WR_ACK: SDA released; sampled 1 => set nack and go to STOP (remaining bytes skipped). Sampled 0 => next byte, or STOP when the remaining count is 0.
- WR_BYTE: wr_req pulses in the first cycle of the state; wr_data is loaded into the shift register that same cycle and shifted out MSB first.
- RD_BYTE:
  - 8 bits sampled MSB first with SDA released.
  - rd_data is updated and rd_valid pulses in the cycle the 8th bit is sampled.
  - RD_ACK: master drives SDA=0 for each non-final byte and releases SDA (NACK) for the final byte.
- STOP slot: SDA=0 in Q0/Q1; SCL=0 in Q0 and 1 from Q1; SDA released in Q2/Q3. done pulses in the cycle after Q3 ends, and the FSM is in IDLE that same cycle.
- Latency from accept to done (no NACK): (2 + 9*(1+cmd_len)) * 4*CLK_DIV cycles, ±1 cycle for the accept register. With an address NACK: 11*4*CLK_DIV.
- cmd_len=0: address plus ACK, then STOP; no wr_req or rd_valid.
- cmd_valid while busy is ignored, with no queueing.
- The byte counter is LEN_W bits, decremented per byte, and never wraps: the FSM leaves the data loop at 0.
- Simultaneous NACK on the last byte: flag set, single STOP, single done.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-idle -> SCL=1, SDA=Z (pull-up reads 1), cmd_ready=1, all pulses 0.
- Write burst (CLK_DIV=4): addr=0x55, rw=0, len=2, bytes 0xA5, 0x3C, slave ACKs all -> SDA carries 0xAA, 0xA5, 0x3C; exactly 2 wr_req pulses; done 464 cycles after accept (±1); nack=0.
- Read burst: addr=0x48, rw=1, len=2, slave sends 0x9E then 0x01 -> address byte 0x91; rd_valid twice with rd_data 0x9E, 0x01; master ACK=0 after byte 1 and SDA released after byte 2; done.
- Address NACK: no slave, len=3 write -> nack=1 after ADDR_ACK, zero wr_req, STOP then done at 176 cycles (±1); nack stays 1 until the next accept.
- Reset mid-byte: assert rst during the 4th bit of a write data byte -> SCL=1 and SDA=Z immediately; after release, a new len=1 write completes normally.
- Probe / busy: len=0 on addr 0x20 with ACK -> done at 176 cycles, no data strobes; a cmd_valid pulse during the transfer has no effect (one done only).
